csr_arbiter: RTL

CSR_ARBITER -- requirements
Module: csr_arbiter

---
 rtl/csr_arbiter_pkg.sv | 26 ++
 rtl/csr_arbiter_if.sv | 40 ++++
 rtl/csr_arbiter_pick.sv | 52 +++++
 rtl/csr_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/csr_arbiter_pkg.sv
// ============================================================================
// Module      : csr_arbiter_pkg
// Description : Shared CSR arbiter definitions: FSM encoding, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csr_arbiter_pkg;

    localparam int c_CSR_ADDR_W = 12;
    localparam int c_CSR_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [1:0] f_onehot(input logic i_idx);
        return i_idx ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/csr_arbiter_if.sv
// ============================================================================
// Module      : csr_arbiter_if
// Description : Two-master request/grant bus plus CSR-side signals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csr_arbiter_if
    import csr_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = c_CSR_ADDR_W,
    parameter int DATA_WIDTH = c_CSR_DATA_W
) ();

    logic [1:0]              req;
    logic [1:0]              lock;
    logic [1:0]              we;
    logic [2*ADDR_WIDTH-1:0] addr;
    logic [2*DATA_WIDTH-1:0] wdata;
    logic [1:0]              gnt;
    logic [1:0]              done;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [ADDR_WIDTH-1:0]   csr_addr_o;
    logic                    csr_ack_o;
    logic [DATA_WIDTH-1:0]   csr_data_o;
    logic [DATA_WIDTH-1:0]   csr_data_i;

    modport slave (
        input  req, lock, we, addr, wdata, csr_data_i,
        output gnt, done, rdata, csr_addr_o, csr_ack_o, csr_data_o
    );

    modport master (
        output req, lock, we, addr, wdata, csr_data_i,
        input  gnt, done, rdata, csr_addr_o, csr_ack_o, csr_data_o
    );

endinterface

`default_nettype wire

// File: rtl/csr_arbiter_pick.sv
// ============================================================================
// Module      : csr_arb_pick
// Description : Combinational winner selection honouring lock and round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_arb_pick
    import csr_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_lock_held,
    input  logic       i_lock_owner,
    output logic       o_valid,
    output logic       o_idx
);

    always_comb begin
        o_valid = 1'b0;
        o_idx   = 1'b0;
        if (i_lock_held) begin
            // A held lock blocks the other master entirely, even if the owner is quiet.
            if (i_req[i_lock_owner]) begin
                o_valid = 1'b1;
                o_idx   = i_lock_owner;
            end
        end else begin
            case (i_req)
                2'b01: begin
                    o_valid = 1'b1;
                    o_idx   = 1'b0;
                end
                2'b10: begin
                    o_valid = 1'b1;
                    o_idx   = 1'b1;
                end
                2'b11: begin
                    o_valid = 1'b1;
                    o_idx   = ~i_last;
                end
                default: begin
                    o_valid = 1'b0;
                    o_idx   = 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/csr_arbiter.sv
// ============================================================================
// Module      : csr_arbiter
// Description : Two-master CSR arbiter with burst lock and fixed 4-cycle access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_arbiter
    import csr_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = c_CSR_ADDR_W,
    parameter int DATA_WIDTH   = c_CSR_DATA_W,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    csr_arbiter_if.slave bus
);

    localparam int c_TMO_W = $clog2(LOCK_TIMEOUT + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_pick_valid;
    logic                  w_pick_idx;
    logic                  w_grant;
    logic                  w_tmo_count;
    logic [1:0]            w_gnt;
    logic [1:0]            w_done;
    logic                  w_ack;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    logic                  r_win;
    logic                  r_last;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_lock_held;
    logic                  r_lock_owner;
    logic [c_TMO_W-1:0]    r_tmo_cnt;

    csr_arb_pick u_pick (
        .i_req        (bus.req),
        .i_last       (r_last),
        .i_lock_held  (r_lock_held),
        .i_lock_owner (r_lock_owner),
        .o_valid      (w_pick_valid),
        .o_idx        (w_pick_idx)
    );

    assign w_grant     = (r_state == ST_IDLE) && w_pick_valid;
    assign w_tmo_count = (r_state == ST_IDLE) && !w_pick_valid && r_lock_held
                         && !bus.req[r_lock_owner];
    assign w_sel_addr  = w_pick_idx ? bus.addr[2*ADDR_WIDTH-1 -: ADDR_WIDTH]
                                    : bus.addr[ADDR_WIDTH-1:0];
    assign w_sel_wdata = w_pick_idx ? bus.wdata[2*DATA_WIDTH-1 -: DATA_WIDTH]
                                    : bus.wdata[DATA_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 2'b00;
        w_done      = 2'b00;
        w_ack       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_gnt       = f_onehot(r_win);
                w_ack       = r_we;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_gnt       = f_onehot(r_win);
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_gnt       = f_onehot(r_win);
                w_done      = f_onehot(r_win);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win        <= 1'b0;
            r_last       <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_lock_held  <= 1'b0;
            r_lock_owner <= 1'b0;
            r_tmo_cnt    <= '0;
        end else begin
            if (w_grant) begin
                r_win     <= w_pick_idx;
                r_last    <= w_pick_idx;
                r_we      <= bus.we[w_pick_idx];
                r_addr    <= w_sel_addr;
                r_wdata   <= w_sel_wdata;
                r_tmo_cnt <= '0;
            end else if (w_tmo_count) begin
                if (r_tmo_cnt == c_TMO_W'(LOCK_TIMEOUT - 1)) begin
                    r_lock_held <= 1'b0;
                    r_tmo_cnt   <= '0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
                end
            end
            // CSR read data lands one clock after the address, i.e. during RESP.
            if (r_state == ST_RESP) begin
                r_rdata      <= bus.csr_data_i;
                r_lock_held  <= bus.lock[r_win];
                r_lock_owner <= r_win;
            end
        end
    end

    assign bus.gnt        = w_gnt;
    assign bus.done       = w_done;
    assign bus.rdata      = r_rdata;
    assign bus.csr_addr_o = r_addr;
    assign bus.csr_ack_o  = w_ack;
    assign bus.csr_data_o = r_wdata;

endmodule

`default_nettype wire
